// File: rtl/fp_multiplier_if.sv
// Request/result bus of the iterative single-precision multiplier.
// The datapath side uses the slave modport; the sequencer side uses master.
interface fp_multiplier_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Out;

    modport master (output start, A, B, input busy, done, Out);
    modport slave  (input start, A, B, output busy, done, Out);
endinterface

// File: rtl/fp_multiplier.sv
// Iterative IEEE-754 single multiplier: 24 shift-add cycles, then normalize/round with a done pulse.
// Optional macro FP_MUL_RNE_EN selects round-to-nearest-even; truncation otherwise.
module fp_multiplier #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic            clk,
    input logic            reset_n,
    fp_multiplier_if.slave bus
);
    localparam int unsigned FP_W   = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned XE_W   = EXP_W + 2;
    localparam int unsigned CNT_W  = $clog2(SIG_W);

    localparam logic [CNT_W-1:0]       LAST_ITER = CNT_W'(SIG_W - 1);
    localparam logic signed [XE_W-1:0] BIAS      = XE_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XE_W-1:0] EXP_MAX   = XE_W'((1 << EXP_W) - 1);
    localparam logic signed [XE_W-1:0] ONE_S     = XE_W'(1);
    localparam logic signed [XE_W-1:0] ZERO_S    = XE_W'(0);
    localparam logic [FP_W-1:0]        QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [FP_W-1:0]   a_q, a_d;
    logic [FP_W-1:0]   b_q, b_d;
    // Upper half accumulates partial sums; lower half starts as the multiplier and shifts out.
    logic [PROD_W-1:0] p_q, p_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [FP_W-1:0]   out_q, out_d;

    logic [SIG_W:0]    step_sum_c;
    logic [EXP_W-1:0]  a_exp_c, b_exp_c;
    logic [MAN_W-1:0]  a_man_c, b_man_c;
    logic              sign_c;
    logic              a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;
    logic signed [XE_W-1:0] exp_sum_c, exp_norm_c, exp_rnd_c;
    logic [MAN_W-1:0]  man_c;
    logic [MAN_W:0]    man_rnd_c;
    logic              round_up_c;
    logic [FP_W-1:0]   result_c;
`ifdef FP_MUL_RNE_EN
    logic              guard_c, rnd_c, sticky_c;
`endif

    // Operand fields and classification; denormals fall into the zero class.
    assign a_exp_c  = a_q[FP_W-2:MAN_W];
    assign b_exp_c  = b_q[FP_W-2:MAN_W];
    assign a_man_c  = a_q[MAN_W-1:0];
    assign b_man_c  = b_q[MAN_W-1:0];
    assign sign_c   = a_q[FP_W-1] ^ b_q[FP_W-1];
    assign a_nan_c  = (&a_exp_c) & (|a_man_c);
    assign b_nan_c  = (&b_exp_c) & (|b_man_c);
    assign a_inf_c  = (&a_exp_c) & ~(|a_man_c);
    assign b_inf_c  = (&b_exp_c) & ~(|b_man_c);
    assign a_zero_c = ~(|a_exp_c);
    assign b_zero_c = ~(|b_exp_c);

    assign exp_sum_c = $signed({{(XE_W-EXP_W){1'b0}}, a_exp_c})
                     + $signed({{(XE_W-EXP_W){1'b0}}, b_exp_c}) - BIAS;

    // One shift-add step: add the multiplicand when the multiplier LSB is set.
    assign step_sum_c = {1'b0, p_q[PROD_W-1:SIG_W]}
                      + (p_q[0] ? {2'b01, a_man_c} : {(SIG_W+1){1'b0}});

    // Normalize, round and resolve special operands into the final result.
    always_comb begin
        man_c      = p_q[PROD_W-3 -: MAN_W];
        exp_norm_c = exp_sum_c;
        round_up_c = 1'b0;
`ifdef FP_MUL_RNE_EN
        guard_c    = p_q[PROD_W-3-MAN_W];
        rnd_c      = p_q[PROD_W-4-MAN_W];
        sticky_c   = |p_q[PROD_W-5-MAN_W:0];
`endif
        if (p_q[PROD_W-1]) begin
            man_c      = p_q[PROD_W-2 -: MAN_W];
            exp_norm_c = exp_sum_c + ONE_S;
`ifdef FP_MUL_RNE_EN
            guard_c    = p_q[PROD_W-2-MAN_W];
            rnd_c      = p_q[PROD_W-3-MAN_W];
            sticky_c   = |p_q[PROD_W-4-MAN_W:0];
`endif
        end
`ifdef FP_MUL_RNE_EN
        round_up_c = guard_c & (rnd_c | sticky_c | man_c[0]);
`endif
        man_rnd_c = {1'b0, man_c} + {{MAN_W{1'b0}}, round_up_c};
        exp_rnd_c = man_rnd_c[MAN_W] ? (exp_norm_c + ONE_S) : exp_norm_c;

        if (a_nan_c || b_nan_c || (a_inf_c && b_zero_c) || (b_inf_c && a_zero_c)) begin
            result_c = QNAN;
        end else if (a_inf_c || b_inf_c) begin
            result_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero_c || b_zero_c) begin
            result_c = {sign_c, {(FP_W-1){1'b0}}};
        end else if (exp_rnd_c >= EXP_MAX) begin
            result_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_rnd_c <= ZERO_S) begin
            result_c = {sign_c, {(FP_W-1){1'b0}}};
        end else begin
            result_c = {sign_c, exp_rnd_c[EXP_W-1:0], man_rnd_c[MAN_W-1:0]};
        end
    end

    // Sequencing; NORM also spans the done cycle so a start there is ignored.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    p_d     = {{SIG_W{1'b0}}, 1'b1, bus.B[MAN_W-1:0]};
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                p_d   = {step_sum_c, p_q[SIG_W-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    out_d  = result_c;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Out  = out_q;
endmodule

// File: tb/tb_fp_multiplier.sv
// Bench for fp_multiplier: arithmetic reference model plus a cycle-level output model,
// compared every cycle, with directed literal cases and randomized operands.
module tb_fp_multiplier;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    fp_multiplier_if bus ();

    fp_multiplier dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Product computed from the IEEE rules with integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e, sh;
        longint ma, mb, p, mant;
        logic   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
`ifdef FP_MUL_RNE_EN
        longint rem, half;
`endif
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        ma = longint'(a[22:0]) + 64'h800000;
        mb = longint'(b[22:0]) + 64'h800000;
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (longint'(1) << 47)) begin
            e++;
            sh = 24;
        end else begin
            sh = 23;
        end
        mant = p >> sh;
`ifdef FP_MUL_RNE_EN
        rem  = p - (mant << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant++;
`endif
        if (mant == (longint'(1) << 24)) begin
            mant = mant >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(mant)};
    endfunction

    // Observable timing: result 25 edges after an accepted start, busy until the edge after that.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_out  = '0;
    logic [31:0] m_res  = '0;
    int          m_cnt  = 0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_cnt  <= 0;
            chk_en <= 1'b1;
        end else if (m_cnt > 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 2);
            if (m_cnt == 2) m_out <= m_res;
            if (m_cnt == 1) m_busy <= 1'b0;
        end else if (bus.start) begin
            m_cnt  <= 26;
            m_res  <= ref_mul(bus.A, bus.B);
            m_busy <= 1'b1;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
            check("done", {31'd0, bus.done}, {31'd0, m_done});
            check("Out", bus.Out, m_out);
        end
    end

    // Called at a negedge; the start is sampled at the following rising edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] expv, input int spur);
        int lat    = 0;
        int busy_n = 0;
        if (bus.busy) busy_n++;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = (spur != 0) && (k == spur);
            if ((spur != 0) && (k == spur)) begin
                bus.A = $urandom;
                bus.B = $urandom;
            end
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, 32'(lat), 32'd25);
        check({name, " result"}, bus.Out, expv);
        check({name, " busy cycles"}, 32'(busy_n), 32'd26);
        @(negedge clk);
        bus.start = 1'b0;
        check({name, " busy after"}, {31'd0, bus.busy}, 32'd0);
        check({name, " done after"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv);
        start_op(a, b);
        wait_done(name, expv, 0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] m;
        int          sel;
        s   = 1'($urandom);
        m   = 23'($urandom);
        sel = int'($urandom_range(0, 11));
        case (sel)
            0: return {s, 8'd0, (($urandom_range(0, 1) == 0) ? 23'd0 : m)};
            1: return {s, 8'hFF, 23'd0};
            2: return {s, 8'hFF, m | 23'd1};
            3: return {s, 8'($urandom_range(200, 254)), m};
            4: return {s, 8'($urandom_range(1, 60)), m};
            5: return {s, 8'd127, 23'($urandom_range(0, 3))};
            default: return {s, 8'($urandom_range(90, 165)), m};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, out_at_done;
        int          dn, dn_at, spur, gap;

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset Out", bus.Out, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run("1.5x2", 32'h3FC00000, 32'h40000000, 32'h40400000);
        run("-2x0.5", 32'hC0000000, 32'h3F000000, 32'hBF800000);
        run("inf x 0", 32'h7F800000, 32'h00000000, 32'h7FC00000);
        run("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
        run("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
`ifdef FP_MUL_RNE_EN
        run("tie to even", 32'h3F800001, 32'h3FC00000, 32'h3FC00002);
`else
        run("truncate", 32'h3F800001, 32'h3FC00000, 32'h3FC00001);
`endif
        run("nan in", 32'h7FC12345, 32'h3F800000, 32'h7FC00000);
        run("-inf x 2", 32'hFF800000, 32'h40000000, 32'hFF800000);
        run("denorm x -1", 32'h00012345, 32'hBF800000, 32'h80000000);

        // Starts sampled at edges 5, 25 and 26 are ignored; edge 27 is accepted.
        start_op(32'h3FC00000, 32'h40000000);
        dn = 0;
        dn_at = 0;
        out_at_done = '0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 4) bus.start = 1'b1;
            if (k == 5) bus.start = 1'b0;
            if (k == 24) bus.start = 1'b1;
            if (k == 25) begin
                bus.A = 32'h40000000;
                bus.B = 32'h40000000;
            end
            if (bus.done) begin
                dn++;
                dn_at = k;
                out_at_done = bus.Out;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("ignored starts done count", 32'(dn), 32'd1);
        check("ignored starts done edge", 32'(dn_at), 32'd25);
        check("ignored starts result", out_at_done, 32'h40400000);
        check("start after done accepted", {31'd0, bus.busy}, 32'd1);
        wait_done("2x2 after done", 32'h40800000, 0);

        // Synchronous reset at edge 10 of an operation discards it.
        start_op(32'h40400000, 32'h40400000);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midop reset busy", {31'd0, bus.busy}, 32'd0);
        check("midop reset done", {31'd0, bus.done}, 32'd0);
        check("midop reset Out", bus.Out, 32'd0);
        reset_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("no done after reset", 32'(dn), 32'd0);
        run("after reset", 32'h3FC00000, 32'h40000000, 32'h40400000);

        for (int i = 0; i < 150; i++) begin
            a    = rand_fp();
            b    = rand_fp();
            spur = (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : 0);
            gap  = int'($urandom_range(0, 2));
            start_op(a, b);
            wait_done("random", ref_mul(a, b), spur);
            repeat (gap) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
